reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 21 ++
 rtl/reset_sequencer_if.sv | 30 +++
 rtl/button_debounce.sv | 51 +++++
 rtl/reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_reset_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : reset_seq_pkg
// Brief  : Sequencer state encoding and shared counter widths.
// Rev    : 1.0
// ============================================================================
package reset_seq_pkg;

  localparam int CNT_W = 16;
  localparam int LFC_W = 4;

  typedef enum logic [2:0] {
    S_DCM_RST   = 3'd0,
    S_LOCK_WAIT = 3'd1,
    S_CPU_RST   = 3'd2,
    S_BOOT      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : reset_sequencer_if
// Brief  : Board/DCM/CPU-facing signals of the reset sequencer.
// Rev    : 1.0
// ============================================================================
interface reset_sequencer_if;
  import reset_seq_pkg::*;

  logic             dcm_locked;
  logic             button_r;
  logic             button_b;
  logic             dcm_reset;
  logic             cpu_reset;
  logic             boot;
  logic             running;
  logic [LFC_W-1:0] lock_fail_count;

  modport master (
    input  dcm_locked, button_r, button_b,
    output dcm_reset, cpu_reset, boot, running, lock_fail_count
  );

  modport slave (
    output dcm_locked, button_r, button_b,
    input  dcm_reset, cpu_reset, boot, running, lock_fail_count
  );

endinterface
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module : button_debounce
// Brief  : Tick-sampled button debouncer emitting one pulse per press.
// Rev    : 1.0
// ============================================================================
module button_debounce #(
  parameter int TICK_BITS    = 6,
  parameter int DEBOUNCE_LEN = 10
) (
  input  wire  cpuclk,
  input  wire  reset,
  input  wire  tick,
  input  wire  btn,
  output logic evt
);

  if (TICK_BITS < 1 || DEBOUNCE_LEN < 2) begin : g_bad_params
    $error("button_debounce: TICK_BITS must be >= 1 and DEBOUNCE_LEN >= 2");
  end

  logic [1:0]              sync_q,    sync_d;
  logic [DEBOUNCE_LEN-1:0] shift_q,   shift_d;
  logic                    pressed_q, pressed_d;

  // Raw button is asynchronous to cpuclk, so it passes a two-flop synchroniser first.
  always_comb begin
    sync_d    = {sync_q[0], btn};
    shift_d   = shift_q;
    if (tick) begin
      shift_d = {shift_q[DEBOUNCE_LEN-2:0], sync_q[1]};
    end
    pressed_d = &shift_q;
  end

  assign evt = pressed_d & ~pressed_q;

  always_ff @(posedge cpuclk) begin
    if (reset) begin
      sync_q    <= '0;
      shift_q   <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      shift_q   <= shift_d;
      pressed_q <= pressed_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module : reset_sequencer
// Brief  : DCM reset/lock, CPU reset and boot sequencing with button resets.
// Rev    : 1.0
// ============================================================================
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int DCM_RESET_CYCLES = 10,
  parameter int LOCK_TIMEOUT     = 1024,
  parameter int RESET_CYCLES     = 40,
  parameter int BOOT_OVERLAP     = 10,
  parameter int BOOT_HOLD        = 10,
  parameter int TICK_BITS        = 6,
  parameter int DEBOUNCE_LEN     = 10
) (
  input wire                cpuclk,
  input wire                reset,
  reset_sequencer_if.master bus
);

  localparam int C_CNT_MAX = (1 << CNT_W) - 1;

  if (DCM_RESET_CYCLES < 1 || DCM_RESET_CYCLES > C_CNT_MAX ||
      LOCK_TIMEOUT     < 1 || LOCK_TIMEOUT     > C_CNT_MAX ||
      RESET_CYCLES     < 1 || RESET_CYCLES     > C_CNT_MAX ||
      BOOT_HOLD        < 1 || BOOT_HOLD        > C_CNT_MAX ||
      BOOT_OVERLAP     < 0 || BOOT_OVERLAP     >= RESET_CYCLES) begin : g_bad_params
    $error("reset_sequencer: cycle parameters must fit the counter and BOOT_OVERLAP < RESET_CYCLES");
  end

  localparam logic [CNT_W-1:0] c_dcm_last  = CNT_W'(DCM_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_lock_last = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_rst_last  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_boot_from = CNT_W'(RESET_CYCLES - BOOT_OVERLAP);
  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(BOOT_HOLD - 1);

  logic [TICK_BITS-1:0] presc_q, presc_d;
  logic                 tick;
  logic                 warm_evt, cold_evt;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LFC_W-1:0]     lfc_q, lfc_d;
  logic                 dcm_reset_q, dcm_reset_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 boot_q, boot_d;
  logic                 running_q, running_d;

  assign presc_d = presc_q + TICK_BITS'(1);
  assign tick    = &presc_q;

  button_debounce #(
    .TICK_BITS   (TICK_BITS),
    .DEBOUNCE_LEN(DEBOUNCE_LEN)
  ) u_deb_warm (
    .cpuclk(cpuclk),
    .reset (reset),
    .tick  (tick),
    .btn   (bus.button_r),
    .evt   (warm_evt)
  );

  button_debounce #(
    .TICK_BITS   (TICK_BITS),
    .DEBOUNCE_LEN(DEBOUNCE_LEN)
  ) u_deb_cold (
    .cpuclk(cpuclk),
    .reset (reset),
    .tick  (tick),
    .btn   (bus.button_b),
    .evt   (cold_evt)
  );

  // Lock loss outranks the buttons; cold also aborts an in-flight CPU reset/boot.
  always_comb begin
    state_d = state_q;
    lfc_d   = lfc_q;
    case (state_q)
      S_DCM_RST: begin
        if (cnt_q == c_dcm_last) state_d = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (bus.dcm_locked) begin
          state_d = S_CPU_RST;
        end else if (cnt_q == c_lock_last) begin
          state_d = S_DCM_RST;
          if (lfc_q != '1) lfc_d = lfc_q + LFC_W'(1);
        end
      end
      S_CPU_RST: begin
        if (!bus.dcm_locked || cold_evt) state_d = S_DCM_RST;
        else if (cnt_q == c_rst_last)    state_d = S_BOOT;
      end
      S_BOOT: begin
        if (!bus.dcm_locked || cold_evt) state_d = S_DCM_RST;
        else if (cnt_q == c_hold_last)   state_d = S_RUN;
      end
      S_RUN: begin
        if (!bus.dcm_locked || cold_evt) state_d = S_DCM_RST;
        else if (warm_evt)               state_d = S_CPU_RST;
      end
      default: state_d = S_DCM_RST;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && state_q != S_RUN) cnt_d = cnt_q + CNT_W'(1);
    dcm_reset_d = (state_d == S_DCM_RST);
    cpu_reset_d = (state_d == S_DCM_RST) || (state_d == S_LOCK_WAIT) ||
                  (state_d == S_CPU_RST);
    boot_d      = ((state_d == S_CPU_RST) && (cnt_d >= c_boot_from)) ||
                  (state_d == S_BOOT);
    running_d   = (state_d == S_RUN);
  end

  always_ff @(posedge cpuclk) begin
    if (reset) begin
      presc_q     <= '0;
      state_q     <= S_DCM_RST;
      cnt_q       <= '0;
      lfc_q       <= '0;
      dcm_reset_q <= 1'b1;
      cpu_reset_q <= 1'b1;
      boot_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfc_q       <= lfc_d;
      dcm_reset_q <= dcm_reset_d;
      cpu_reset_q <= cpu_reset_d;
      boot_q      <= boot_d;
      running_q   <= running_d;
    end
  end

  assign bus.dcm_reset       = dcm_reset_q;
  assign bus.cpu_reset       = cpu_reset_q;
  assign bus.boot            = boot_q;
  assign bus.running         = running_q;
  assign bus.lock_fail_count = lfc_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_reset_sequencer
// Brief  : Scoreboard bench; each expected output change carries the length
//          of the run it ends (0 = length not checked).
// Rev    : 1.0
// ============================================================================
module tb_reset_sequencer;

  logic cpuclk = 1'b0;
  logic reset  = 1'b1;

  reset_sequencer_if bus_if ();

  reset_sequencer #(
    .DCM_RESET_CYCLES(4),
    .LOCK_TIMEOUT    (16),
    .RESET_CYCLES    (8),
    .BOOT_OVERLAP    (2),
    .BOOT_HOLD       (3),
    .TICK_BITS       (2),
    .DEBOUNCE_LEN    (4)
  ) dut (
    .cpuclk(cpuclk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 cpuclk = ~cpuclk;

  // {dcm_reset, cpu_reset, boot, running, lock_fail_count}
  logic [7:0] outs;
  assign outs = {bus_if.dcm_reset, bus_if.cpu_reset, bus_if.boot,
                 bus_if.running, bus_if.lock_fail_count};

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_o_q[$];
  int         exp_len_q[$];
  logic       mon_en = 1'b0;

  task automatic push(input logic [7:0] o, input int len);
    exp_o_q.push_back(o);
    exp_len_q.push_back(len);
  endtask

  // Monitor: every change of the output vector consumes one expectation.
  initial begin : monitor
    logic [7:0] prev;
    logic [7:0] eo;
    int         run;
    int         el;
    prev = 'x;
    run  = 0;
    forever begin
      @(posedge cpuclk);
      #1;
      if (mon_en && outs !== prev) begin
        total++;
        if (exp_o_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: got %h after %0d cycles of %h, required no change",
                   outs, run, prev);
        end else begin
          eo = exp_o_q.pop_front();
          el = exp_len_q.pop_front();
          if (outs !== eo) begin
            bad++;
            $display("FAIL out_change: got %h required %h (t=%0t)", outs, eo, $time);
          end
          if (el != 0) begin
            total++;
            if (run != el) begin
              bad++;
              $display("FAIL run_len: value %h lasted %0d cycles, required %0d (t=%0t)",
                       prev, run, el, $time);
            end
          end
        end
      end
      if (outs !== prev || reset) begin
        prev = outs;
        run  = 1;
      end else begin
        run++;
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_o_q.size() != 0 && n < budget) begin
      @(negedge cpuclk);
      n++;
    end
    total++;
    if (exp_o_q.size() != 0) begin
      bad++;
      $display("FAIL drain_%s: %0d expectations left, required 0", name, exp_o_q.size());
      exp_o_q.delete();
      exp_len_q.delete();
    end
  endtask

  task automatic wait_outs(input logic [7:0] val, input int budget);
    int n;
    n = 0;
    @(posedge cpuclk);
    #1;
    while (outs !== val && n < budget) begin
      @(posedge cpuclk);
      #1;
      n++;
    end
    total++;
    if (outs !== val) begin
      bad++;
      $display("FAIL wait_outs: got %h, required %h within %0d cycles", outs, val, budget);
    end
  endtask

  task automatic expect_powerup();
    push(8'h40, 4);
    push(8'h60, 7);
    push(8'h20, 2);
    push(8'h10, 3);
  endtask

  task automatic expect_warm();
    push(8'h40, 0);
    push(8'h60, 6);
    push(8'h20, 2);
    push(8'h10, 3);
  endtask

  initial begin : stimulus
    bus_if.dcm_locked = 1'b1;
    bus_if.button_r   = 1'b0;
    bus_if.button_b   = 1'b0;
    reset             = 1'b1;

    // Power-up with lock present
    repeat (3) @(negedge cpuclk);
    total++;
    if (outs !== 8'hC0) begin
      bad++;
      $display("FAIL reset_state: got %h required c0", outs);
    end
    mon_en = 1'b1;
    expect_powerup();
    reset = 1'b0;
    wait_drain("powerup", 60);
    repeat (8) @(negedge cpuclk);

    // Warm press held 20 clocks
    expect_warm();
    bus_if.button_r = 1'b1;
    repeat (20) @(negedge cpuclk);
    bus_if.button_r = 1'b0;
    wait_drain("warm", 60);
    repeat (16) @(negedge cpuclk);

    // Bouncing warm button: no event
    for (int i = 0; i < 3; i++) begin
      bus_if.button_r = (i % 2 == 0);
      repeat (4) @(negedge cpuclk);
    end
    bus_if.button_r = 1'b0;
    repeat (30) @(negedge cpuclk);
    total++;
    if (bus_if.running !== 1'b1) begin
      bad++;
      $display("FAIL bounce_running: got %b required 1", bus_if.running);
    end

    // Simultaneous warm+cold: cold path
    push(8'hC0, 0);
    expect_powerup();
    bus_if.button_r = 1'b1;
    bus_if.button_b = 1'b1;
    repeat (20) @(negedge cpuclk);
    bus_if.button_r = 1'b0;
    bus_if.button_b = 1'b0;
    wait_drain("cold", 80);
    repeat (16) @(negedge cpuclk);

    // Lock loss during S_BOOT
    push(8'h40, 0);
    push(8'h60, 6);
    push(8'h20, 2);
    push(8'hC0, 1);
    expect_powerup();
    bus_if.button_r = 1'b1;
    wait_outs(8'h40, 40);
    @(negedge cpuclk);
    bus_if.button_r = 1'b0;
    wait_outs(8'h20, 40);
    @(negedge cpuclk);
    bus_if.dcm_locked = 1'b0;
    @(negedge cpuclk);
    bus_if.dcm_locked = 1'b1;
    wait_drain("lockloss", 80);
    repeat (16) @(negedge cpuclk);

    // Reset asserted in S_CPU_RST
    push(8'h40, 0);
    push(8'hC0, 0);
    expect_powerup();
    bus_if.button_r = 1'b1;
    wait_outs(8'h40, 40);
    @(negedge cpuclk);
    bus_if.button_r = 1'b0;
    reset = 1'b1;
    @(negedge cpuclk);
    total++;
    if (outs !== 8'hC0) begin
      bad++;
      $display("FAIL mid_reset: got %h required c0", outs);
    end
    @(negedge cpuclk);
    reset = 1'b0;
    wait_drain("rerun", 60);
    repeat (8) @(negedge cpuclk);

    // Lock never arrives: retries and saturating fail count
    push(8'hC0, 0);
    push(8'h40, 4);
    for (int k = 1; k <= 15; k++) begin
      push(8'hC0 | 8'(k), 16);
      push(8'h40 | 8'(k), 4);
    end
    push(8'hCF, 16);
    push(8'h4F, 4);
    bus_if.dcm_locked = 1'b0;
    wait_drain("lockfail", 600);
    total++;
    if (bus_if.lock_fail_count !== 4'd15) begin
      bad++;
      $display("FAIL lfc_saturate: got %0d required 15", bus_if.lock_fail_count);
    end
    push(8'hC0, 0);
    @(negedge cpuclk);
    reset = 1'b1;
    @(negedge cpuclk);
    total++;
    if (bus_if.lock_fail_count !== 4'd0) begin
      bad++;
      $display("FAIL lfc_clear: got %0d required 0", bus_if.lock_fail_count);
    end
    wait_drain("final", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
